// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its sequencer:
// USR MODE encodings and the sequencer state type.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/usr_shift_counter.sv
// Down-counter holding the number of shifts still to perform; decrement
// stops at zero.
module usr_shift_counter #(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/usr_shift_sequencer.sv
// Handshaked parallel-to-serial controller driving a universal shift register.
// Define USR_SEQ_FILL_EN to add the fill_bit input used as the serial fill.
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CW-1:0]    in_count,
`ifdef USR_SEQ_FILL_EN
  input  logic             fill_bit,
`endif
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_din,
  input  logic [WIDTH-1:0] usr_dout,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             done
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]    sat_count;

  assign sat_count = (in_count > CW'(WIDTH)) ? CW'(WIDTH) : in_count;

  usr_shift_counter #(.CW(CW)) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (sat_count),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // The LOAD cycle already consumes one count, so SHIFT runs while the
  // counter is non-zero and leaves on the cycle it reads zero.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dir_d    = dir_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          dir_d    = in_dir;
          cnt_load = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mode_d = MODE_HOLD;
    din_d  = '0;
    done_d = 1'b0;
    case (state_d)
      LOAD: begin
        mode_d = MODE_LOAD;
        din_d  = data_d;
      end
      SHIFT:   mode_d = dir_d ? MODE_SHL : MODE_SHR;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= MODE_HOLD;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign ser_valid = (state_q == SHIFT);
  assign ser_bit   = dir_q ? usr_dout[WIDTH-1] : usr_dout[0];
  assign usr_mode  = mode_q;
  assign done      = done_q;

`ifdef USR_SEQ_FILL_EN
  assign usr_din = din_q | {{(WIDTH-1){1'b0}}, fill_bit & (state_q == SHIFT)};
`else
  assign usr_din = din_q;
`endif

endmodule
